wts_wave_memory_scheduler: RTL
==============================

# wts_wave_memory_scheduler

Time-slot scheduler sharing one single-port wave RAM among the five wave-table tone-generator channels and the CPU. Each 6-clock `active` period is split into five channel read slots and one CPU slot. It turns each channel's `wave_address` into a RAM read and holds the returned 8-bit sample per channel for the mixer. It sits between the per-channel tone generators, the CPU register interface and the wave RAM.

## Interface
- CHANNELS, 5: channel count; fixed at 5, must be ≤ 5 so the CPU slot stays at phase 5.
- clk  in  1  system clock (21.477 MHz).
- reset  in  1  asynchronous, active-high; clears all state.
- active  in  1  one-clk timing pulse every 6 clk (3.579 MHz).
- ch_address  in  35  channel n wave_address at [7n+6:7n].
- ch_enable  in  5  per-channel key-on.
- mem_address  out  10  {channel[2:0], address[6:0]} to wave RAM.
- mem_rd  out  1  RAM read strobe; mem_rdata valid the following clk.
- mem_wr  out  1  RAM write strobe.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data; 1-clk latency.
- cpu_req  in  1  single-clk access strobe.
- cpu_wr  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_address  in  10  sampled with cpu_req.
- cpu_wdata  in  8  sampled with cpu_req.
- cpu_busy  out  1  request pending or in flight.
- cpu_ack  out  1  one-clk completion pulse.
- cpu_rdata  out  8  read result; valid from cpu_ack, held until next read ack.
- ch_sample  out  40  channel n held sample at [8n+7:8n].

## Operation
- Phase register `phase` 0..6. Reset value 6 (idle).
- Clock edge with active=1: phase ← 0.
- Otherwise: phase ← phase+1, saturating at 6.
- With a regular `active`, phase cycles 0..5. With no `active`, phase parks at 6.
- Phase k, 0..4: if ch_enable[k], then mem_rd=1 and mem_address={k, ch_address[7k+6:7k]}. If ch_enable[k]=0, no access is made.
- Phase 5: CPU slot. Phase 6: CPU may access on every clk.
- CPU request: cpu_req=1 while cpu_busy=0 latches wr, address and wdata, and sets cpu_busy on the next clk.
  - cpu_req while cpu_busy=1 is ignored and not queued.
- A pending request is issued in the first phase that is 5 or 6, on the mem outputs:
  - mem_rd or mem_wr = 1, mem_address = the latched address, mem_wdata = the latched data.
- Channel return: mem_rdata is captured into ch_sample[k] at the end of phase k+1.
  - A disabled channel's ch_sample[k] is cleared to 0 at that same point.
- CPU return:
  - Read: mem_rdata is captured into cpu_rdata one clk after issue; cpu_ack pulses in that same clk.
  - Write: cpu_ack pulses one clk after issue.
  - cpu_busy clears together with cpu_ack.
- mem_rd and mem_wr are never both 1. At most one access is made per clk.

## Timing
- Reset values:
  - mem_rd=0, mem_wr=0, mem_address=0, mem_wdata=0.
  - ch_sample=0, cpu_rdata=0, cpu_ack=0, cpu_busy=0, phase=6.
- All outputs are registered, with no combinational input→output path.
- Channel latency: active edge → ch_sample[k] updated k+2 clk later.
- CPU latency, worst case: request just after phase 5 → 6 clk wait + 1 clk issue + 1 clk ack. In idle phase 6: issue on the clk after capture.
- `active` arriving early (phase<5): phase restarts at 0 and the skipped slots are lost. A pending CPU access waits for the next phase 5/6.
- `active` asserted at phase 5 while a CPU access is issuing: the access completes normally.
- Reset mid-operation:
  - Pending or in-flight CPU access is dropped, with no cpu_ack.
  - ch_sample is cleared and phase returns to 6.
- ch_address is sampled at the edge entering phase k. Later changes within the period do not affect that read.

## Configuration
- WTS_CPU_STEAL_EN defined: a pending CPU access issues in the next clk whatever the phase.
  - If this displaces channel k in phase 0..4, that channel's read is skipped and ch_sample[k] keeps its old value.
  - The phase counter is unaffected.
- WTS_CPU_STEAL_EN undefined: CPU accesses issue only in phase 5 or 6, as described above.

## Test plan
- Regular active, ch_enable=5'b11111, RAM[{k,a}]=16k+a, ch_address=3 for all channels → ch_sample[k]=16k+3, each updated k+2 clk after the active edge.
- ch_enable[2] dropped to 0 → no mem_rd in phase 2; ch_sample[2]=0 after phase 3; other channels unchanged.
- CPU write 0x5A to 0x045 at phase 1, then read 0x045 → write issues in phase 5; read returns cpu_rdata=0x5A; exactly one cpu_ack per request; second cpu_req while busy is ignored.
- active stopped for 20 clk, CPU read → issues on the clk after capture (phase 6); cpu_ack 2 clk after cpu_req.
- Reset asserted while a CPU read is pending → cpu_busy=0, no cpu_ack, ch_sample=0, no mem_rd until the next active.
- WTS_CPU_STEAL_EN defined, cpu_req at phase 1 → CPU access issues in phase 2; ch_sample[2] keeps its old value; channels 3 and 4 read normally.

Source files
------------

// File: rtl/wts_wave_memory_scheduler.sv
// Time-slot arbiter sharing one single-port wave RAM between five wave-table channels and the CPU.
// Optional macro WTS_CPU_STEAL_EN lets a pending CPU access take the very next clk, displacing a channel slot.
module wts_wave_memory_scheduler #(
  parameter int CHANNELS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  input  logic [7*CHANNELS-1:0]   ch_address,
  input  logic [CHANNELS-1:0]     ch_enable,
  output logic [9:0]              mem_address,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [7:0]              mem_wdata,
  input  logic [7:0]              mem_rdata,
  input  logic                    cpu_req,
  input  logic                    cpu_wr,
  input  logic [9:0]              cpu_address,
  input  logic [7:0]              cpu_wdata,
  output logic                    cpu_busy,
  output logic                    cpu_ack,
  output logic [7:0]              cpu_rdata,
  output logic [8*CHANNELS-1:0]   ch_sample
);

  localparam logic [2:0] PHASE_CPU  = 3'd5;
  localparam logic [2:0] PHASE_IDLE = 3'd6;

  // Tag travelling alongside each RAM access so the return data lands in the right place.
  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_CH_RD,
    TAG_CH_OFF,
    TAG_CPU_RD,
    TAG_CPU_WR
  } tag_e;

  typedef struct packed {
    tag_e       tag;
    logic [2:0] ch;
  } slot_t;

  logic [2:0] phase_q, phase_d;
  logic       pend_q;
  logic       pend_wr_q;
  logic [9:0] pend_addr_q;
  logic [7:0] pend_wdata_q;
  slot_t      slot0_q, slot1_q, slot_d;

  logic       accept, req_valid, req_wr, cpu_slot, issue_cpu, ch_slot;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;
  logic       ch_sel_en;
  logic [6:0] ch_sel_addr;
  logic       mem_rd_d, mem_wr_d;
  logic [9:0] mem_address_d;
  logic [7:0] mem_wdata_d;
  logic [5:0] sample_base;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    phase_d = phase_q;
    if (active)                   phase_d = 3'd0;
    else if (phase_q != PHASE_IDLE) phase_d = phase_q + 3'd1;
  end

  assign accept    = cpu_req && !cpu_busy;
  assign req_valid = pend_q || accept;
  assign req_wr    = pend_q ? pend_wr_q    : cpu_wr;
  assign req_addr  = pend_q ? pend_addr_q  : cpu_address;
  assign req_wdata = pend_q ? pend_wdata_q : cpu_wdata;

`ifdef WTS_CPU_STEAL_EN
  assign cpu_slot = 1'b1;
`else
  assign cpu_slot = (phase_d >= PHASE_CPU);
`endif

  assign issue_cpu = req_valid && cpu_slot;
  assign ch_slot   = (phase_d < 3'(CHANNELS));

  always_comb begin
    ch_sel_en   = 1'b0;
    ch_sel_addr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (phase_d == 3'(i)) begin
        ch_sel_en   = ch_enable[i];
        ch_sel_addr = ch_address[7*i +: 7];
      end
    end
  end

  // Next RAM command is decided from the phase being entered, so every mem output is a register.
  always_comb begin
    mem_rd_d      = 1'b0;
    mem_wr_d      = 1'b0;
    mem_address_d = mem_address;
    mem_wdata_d   = mem_wdata;
    slot_d        = '{tag: TAG_NONE, ch: 3'd0};
    if (issue_cpu) begin
      mem_rd_d      = !req_wr;
      mem_wr_d      = req_wr;
      mem_address_d = req_addr;
      if (req_wr) mem_wdata_d = req_wdata;
      slot_d.tag    = req_wr ? TAG_CPU_WR : TAG_CPU_RD;
    end else if (ch_slot) begin
      slot_d.ch = phase_d;
      if (ch_sel_en) begin
        mem_rd_d      = 1'b1;
        mem_address_d = {phase_d, ch_sel_addr};
        slot_d.tag    = TAG_CH_RD;
      end else begin
        slot_d.tag    = TAG_CH_OFF;
      end
    end
  end

  assign sample_base = {slot1_q.ch, 3'b000};

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= PHASE_IDLE;
      pend_q       <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      slot0_q      <= '{tag: TAG_NONE, ch: 3'd0};
      slot1_q      <= '{tag: TAG_NONE, ch: 3'd0};
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      cpu_busy     <= 1'b0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
      ch_sample    <= '0;
    end else begin
      phase_q     <= phase_d;
      mem_rd      <= mem_rd_d;
      mem_wr      <= mem_wr_d;
      mem_address <= mem_address_d;
      mem_wdata   <= mem_wdata_d;
      slot0_q     <= slot_d;
      slot1_q     <= slot0_q;
      pend_q      <= req_valid && !issue_cpu;
      if (accept) begin
        pend_wr_q    <= cpu_wr;
        pend_addr_q  <= cpu_address;
        pend_wdata_q <= cpu_wdata;
      end

      // Return path: slot1 marks the clk in which mem_rdata belongs to that access.
      cpu_ack <= (slot1_q.tag == TAG_CPU_RD) || (slot1_q.tag == TAG_CPU_WR);
      if (accept)
        cpu_busy <= 1'b1;
      else if ((slot1_q.tag == TAG_CPU_RD) || (slot1_q.tag == TAG_CPU_WR))
        cpu_busy <= 1'b0;
      if (slot1_q.tag == TAG_CPU_RD) cpu_rdata <= mem_rdata;

      case (slot1_q.tag)
        TAG_CH_RD:  ch_sample[sample_base +: 8] <= mem_rdata;
        TAG_CH_OFF: ch_sample[sample_base +: 8] <= 8'h00;
        default: ;
      endcase
    end
  end

endmodule
